// File: rtl/argmax_axis_packer.sv
// Sequential argmax over a class-sum vector; results are queued and streamed out on M00_AXIS.
// Optional macro ARGMAX_SUM_OUT_EN stores the winning sum and places it in tdata[31:16].
module argmax_axis_packer #(
   parameter int CLASS_NUM              = 10,
   parameter int WEIGHT_LENGTH          = 7,
   parameter int C_M00_AXIS_TDATA_WIDTH = 64,
   parameter int FIFO_DEPTH             = 4,
   parameter int IDX_WIDTH              = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1
) (
   input  logic                                  m00_axis_aclk,
   input  logic                                  m00_axis_aresetn,
   input  logic                                  sum_valid,
   output logic                                  sum_ready,
   input  logic [CLASS_NUM*WEIGHT_LENGTH-1:0]    class_sums,
   input  logic                                  sum_last,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tkeep,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
   output logic                                  m00_axis_tlast
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int KEEP_W = C_M00_AXIS_TDATA_WIDTH / 8;
`ifdef ARGMAX_SUM_OUT_EN
   localparam int ENTRY_W = 1 + IDX_WIDTH + WEIGHT_LENGTH;
`else
   localparam int ENTRY_W = 1 + IDX_WIDTH;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, PUSH = 2'd2} state_t;

   function automatic logic [15:0] sext16(input logic [WEIGHT_LENGTH-1:0] v);
      return 16'($signed(v));
   endfunction

   state_t                               state_q;
   logic                                 sum_ready_q;
   logic [CLASS_NUM*WEIGHT_LENGTH-1:0]   sums_q;
   logic                                 last_q;
   logic [IDX_WIDTH-1:0]                 scan_idx_q;
   logic [IDX_WIDTH-1:0]                 best_idx_q;
   logic [WEIGHT_LENGTH-1:0]             best_sum_q;

   logic [ENTRY_W-1:0]                   mem_q [FIFO_DEPTH];
   logic [PTR_W:0]                       wr_ptr_q;
   logic [PTR_W:0]                       rd_ptr_q;

   logic                                 full_s;
   logic                                 empty_s;
   logic                                 push_s;
   logic                                 pop_s;
   logic [WEIGHT_LENGTH-1:0]             cur_sum_s;
   logic [ENTRY_W-1:0]                   push_entry_s;
   logic [ENTRY_W-1:0]                   rd_entry_s;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0]    tdata_s;

   // The extra pointer MSB separates full from empty when the index bits match.
   assign full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign push_s  = (state_q == PUSH) && !full_s;
   assign pop_s   = !empty_s && m00_axis_tready;

   // Unscanned sums are shifted down so the next candidate is always in the low slot.
   assign cur_sum_s  = sums_q[WEIGHT_LENGTH-1:0];
   assign rd_entry_s = mem_q[rd_ptr_q[PTR_W-1:0]];
`ifdef ARGMAX_SUM_OUT_EN
   assign push_entry_s = {last_q, best_idx_q, best_sum_q};
`else
   assign push_entry_s = {last_q, best_idx_q};
`endif

   // Scan controller: accept, walk classes with strict-greater compare, push result.
   always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
      if (!m00_axis_aresetn) begin
         state_q     <= IDLE;
         sum_ready_q <= 1'b0;
         sums_q      <= '0;
         last_q      <= 1'b0;
         scan_idx_q  <= '0;
         best_idx_q  <= '0;
         best_sum_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sum_valid && sum_ready_q) begin
                  sums_q      <= class_sums >> WEIGHT_LENGTH;
                  last_q      <= sum_last;
                  best_idx_q  <= '0;
                  best_sum_q  <= class_sums[WEIGHT_LENGTH-1:0];
                  scan_idx_q  <= IDX_WIDTH'(1);
                  sum_ready_q <= 1'b0;
                  state_q     <= (CLASS_NUM == 1) ? PUSH : SCAN;
               end else begin
                  sum_ready_q <= 1'b1;
               end
            end
            SCAN: begin
               if ($signed(cur_sum_s) > $signed(best_sum_q)) begin
                  best_idx_q <= scan_idx_q;
                  best_sum_q <= cur_sum_s;
               end else begin
                  best_idx_q <= best_idx_q;
               end
               sums_q     <= sums_q >> WEIGHT_LENGTH;
               scan_idx_q <= scan_idx_q + IDX_WIDTH'(1);
               if (scan_idx_q == IDX_WIDTH'(CLASS_NUM - 1)) begin
                  state_q <= PUSH;
               end else begin
                  state_q <= SCAN;
               end
            end
            PUSH: begin
               if (!full_s) begin
                  state_q     <= IDLE;
                  sum_ready_q <= 1'b1;
               end else begin
                  state_q <= PUSH;
               end
            end
            default: begin
               state_q     <= IDLE;
               sum_ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Result FIFO storage and pointers; no bypass, so a push shows up one cycle later.
   always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
      if (!m00_axis_aresetn) begin
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_q[k] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry_s;
            wr_ptr_q                   <= wr_ptr_q + (PTR_W+1)'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
         end
      end
   end

   // Output word formatting from the FIFO head.
   always_comb begin
      tdata_s = '0;
      if (!empty_s) begin
         tdata_s[15:0] = 16'(rd_entry_s[ENTRY_W-2 -: IDX_WIDTH]);
`ifdef ARGMAX_SUM_OUT_EN
         tdata_s[31:16] = sext16(rd_entry_s[WEIGHT_LENGTH-1:0]);
`endif
      end else begin
         tdata_s = '0;
      end
   end

   assign sum_ready       = sum_ready_q;
   assign m00_axis_tvalid = !empty_s;
   assign m00_axis_tdata  = tdata_s;
   assign m00_axis_tlast  = !empty_s && rd_entry_s[ENTRY_W-1];
   assign m00_axis_tkeep  = {KEEP_W{!empty_s}};
   assign m00_axis_tstrb  = {KEEP_W{!empty_s}};

endmodule

// File: tb/tb_argmax_axis_packer.sv
// Directed bench for argmax_axis_packer: latency, ties, backpressure, reset and ignored input.
module tb_argmax_axis_packer;

   localparam int C  = 10;
   localparam int W  = 7;
   localparam int DW = 64;

   logic              clk;
   logic              rst_n;
   logic              sum_valid;
   logic              sum_ready;
   logic [C*W-1:0]    class_sums;
   logic              sum_last;
   logic              tready;
   logic              tvalid;
   logic [DW-1:0]     tdata;
   logic [DW/8-1:0]   tkeep;
   logic [DW/8-1:0]   tstrb;
   logic              tlast;

   int n_vec  = 0;
   int n_miss = 0;

   int vals [5][10] = '{
      '{3, -5, 12, 0, 12, 1, -64, 7, 2, 11},
      '{-64, -64, -64, -64, -64, -64, -64, -64, -64, -63},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{-1, 63, -3, 63, -5, -6, -7, -8, -9, -10},
      '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -1}
   };
   int e_idx  [5] = '{2, 9, 0, 1, 9};
   int e_sum  [5] = '{12, -63, 0, 63, -1};
   int e_last [5] = '{0, 1, 0, 0, 1};

   argmax_axis_packer #(
      .CLASS_NUM(C), .WEIGHT_LENGTH(W), .C_M00_AXIS_TDATA_WIDTH(DW), .FIFO_DEPTH(4)
   ) dut (
      .m00_axis_aclk(clk),
      .m00_axis_aresetn(rst_n),
      .sum_valid(sum_valid),
      .sum_ready(sum_ready),
      .class_sums(class_sums),
      .sum_last(sum_last),
      .m00_axis_tready(tready),
      .m00_axis_tvalid(tvalid),
      .m00_axis_tdata(tdata),
      .m00_axis_tkeep(tkeep),
      .m00_axis_tstrb(tstrb),
      .m00_axis_tlast(tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_word(input int k);
      logic [63:0] w;
      w       = '0;
      w[15:0] = 16'(e_idx[k]);
`ifdef ARGMAX_SUM_OUT_EN
      w[31:16] = 16'(e_sum[k]);
`endif
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for sum_ready, presents vector k for exactly the accepting edge.
   task automatic send(input int k);
      int to;
      to = 0;
      while (!sum_ready && to < 200) begin
         step();
         to++;
      end
      if (to >= 200) check_eq("send_timeout", 64'(to), 64'd0);
      for (int i = 0; i < C; i++) class_sums[i*W +: W] = W'(vals[k][i]);
      sum_last  = e_last[k][0];
      sum_valid = 1'b1;
      step();
      sum_valid = 1'b0;
   endtask

   task automatic wait_beat(input int k, input string tag);
      int to;
      to = 0;
      while (!tvalid && to < 100) begin
         step();
         to++;
      end
      check_eq({tag, "_valid"}, 64'(tvalid), 64'd1);
      check_eq({tag, "_data"}, tdata, exp_word(k));
      check_eq({tag, "_last"}, 64'(tlast), 64'(e_last[k]));
      step();
   endtask

   initial begin
      int lat;
      int beats;
      int extra;
      rst_n = 1'b0; sum_valid = 1'b0; class_sums = '0; sum_last = 1'b0; tready = 1'b1;
      #12;
      check_eq("rst_tvalid", 64'(tvalid), 64'd0);
      check_eq("rst_tdata", tdata, 64'd0);
      check_eq("rst_tkeep", 64'(tkeep), 64'd0);
      check_eq("rst_tlast", 64'(tlast), 64'd0);
      check_eq("rst_sum_ready", 64'(sum_ready), 64'd0);
      @(posedge clk); #3 rst_n = 1'b1;
      step(); step();
      check_eq("idle_ready", 64'(sum_ready), 64'd1);

      // Latency and tie-break.
      send(0);
      lat = 0;
      while (!tvalid && lat < 50) begin
         step();
         lat++;
      end
      check_eq("latency", 64'(lat), 64'd10);
      check_eq("tie_data", tdata, exp_word(0));
      check_eq("tie_last", 64'(tlast), 64'd0);
      check_eq("tkeep", 64'(tkeep), 64'hFF);
      check_eq("tstrb", 64'(tstrb), 64'hFF);
      step();
      check_eq("popped", 64'(tvalid), 64'd0);

      send(1);
      wait_beat(1, "neg_max");

      // Backpressure: four queued, fifth parked in PUSH.
      tready = 1'b0;
      for (int k = 0; k < 5; k++) send(k);
      repeat (15) step();
      check_eq("stall_ready", 64'(sum_ready), 64'd0);
      check_eq("stall_head", tdata, exp_word(0));
      tready = 1'b1;
      beats = 0;
      for (int c = 0; c < 100 && beats < 5; c++) begin
         if (tvalid) begin
            check_eq("drain_data", tdata, exp_word(beats));
            beats++;
         end
         step();
      end
      extra = 0;
      repeat (20) begin
         if (tvalid) extra++;
         step();
      end
      check_eq("drain_count", 64'(beats + extra), 64'd5);

      // Random backpressure over 20 vectors.
      fork
         begin : producer
            for (int v = 0; v < 20; v++) send(v % 5);
         end
         begin : consumer
            logic        hold;
            logic [63:0] held_data;
            logic        held_last;
            int          nb;
            hold = 1'b0; held_data = '0; held_last = 1'b0; nb = 0;
            for (int c = 0; c < 3000 && nb < 20; c++) begin
               step();
               if (hold) begin
                  check_eq("hold_valid", 64'(tvalid), 64'd1);
                  check_eq("hold_data", tdata, held_data);
                  check_eq("hold_last", 64'(tlast), 64'(held_last));
               end
               tready = 1'($urandom_range(0, 1));
               if (tvalid && tready) begin
                  check_eq("rnd_data", tdata, exp_word(nb % 5));
                  nb++;
                  hold = 1'b0;
               end else begin
                  hold = tvalid;
               end
               held_data = tdata;
               held_last = tlast;
            end
            check_eq("rnd_count", 64'(nb), 64'd20);
         end
      join
      tready = 1'b1;
      repeat (5) step();

      // Reset mid-scan with two entries pending.
      tready = 1'b0;
      send(0); send(1); send(2);
      repeat (3) step();
      check_eq("pre_rst_valid", 64'(tvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_tvalid", 64'(tvalid), 64'd0);
      check_eq("async_tkeep", 64'(tkeep), 64'd0);
      check_eq("async_ready", 64'(sum_ready), 64'd0);
      @(posedge clk); #3 rst_n = 1'b1;
      tready = 1'b1;
      extra = 0;
      repeat (20) begin
         step();
         if (tvalid) extra++;
      end
      check_eq("no_stale", 64'(extra), 64'd0);
      send(3);
      wait_beat(3, "post_rst");

      // sum_valid while busy is ignored.
      send(4);
      step();
      for (int i = 0; i < C; i++) class_sums[i*W +: W] = W'(vals[0][i]);
      sum_valid = 1'b1;
      check_eq("busy_ready", 64'(sum_ready), 64'd0);
      repeat (5) step();
      sum_valid = 1'b0;
      beats = 0;
      repeat (40) begin
         if (tvalid) begin
            check_eq("busy_data", tdata, exp_word(4));
            beats++;
         end
         step();
      end
      check_eq("busy_count", 64'(beats), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
